// File: rtl/simple_ser_pkg.sv
// simple_ser_pkg: shared types and frame-length helper for simple_ser_tx (parity via SIMPLE_SER_TX_PARITY_EN)
package simple_ser_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int DEF_WIDTH = 6;

    function automatic int frame_len(input int width);
`ifdef SIMPLE_SER_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/simple_ser_tx_if.sv
// simple_ser_tx_if: word handshake in, serial frame out
interface simple_ser_tx_if import simple_ser_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;

    modport master (output in_valid, in_data, input in_ready, ser_out, ser_valid, ser_last);
    modport slave  (input in_valid, in_data, output in_ready, ser_out, ser_valid, ser_last);

endinterface

// File: rtl/ser_bit_stage.sv
// ser_bit_stage: one shift-register bit, load wins over shift
module ser_bit_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic shift,
    input  logic load_bit,
    input  logic shift_in,
    output logic q
);

    // hold, load a new word bit, or take the neighbour's bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else if (load) q <= load_bit;
        else if (shift) q <= shift_in;

endmodule

// File: rtl/simple_ser_tx.sv
// simple_ser_tx: LSB-first parallel-to-serial transmitter; SIMPLE_SER_TX_PARITY_EN appends an even-parity bit
module simple_ser_tx import simple_ser_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    simple_ser_tx_if.slave bus
);

    localparam int FL = frame_len(WIDTH);
    localparam int CW = $clog2(FL + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0] chain;
    logic           at_last, accept, out_bit;
    logic           so, sv, sl;

    assign at_last      = state == SHIFT && cnt == CW'(FL - 1);
    assign bus.in_ready = state == IDLE || at_last;
    assign accept       = bus.in_valid && bus.in_ready;
    assign chain        = {1'b0, q};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        ser_bit_stage u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (accept),
            .shift    (state == SHIFT),
            .load_bit (bus.in_data[i]),
            .shift_in (chain[i+1]),
            .q        (q[i])
        );
    end

`ifdef SIMPLE_SER_TX_PARITY_EN
    logic par;

    // capture even parity of the accepted word for the trailing frame bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) par <= 1'b0;
        else if (accept) par <= ^bus.in_data;

    assign out_bit = cnt == CW'(WIDTH) ? par : q[0];
`else
    assign out_bit = q[0];
`endif

    // state and bit counter registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    // a new word restarts the frame; otherwise count bits until the last one is sent
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
        end else if (at_last) state_nx = IDLE;
        else if (state == SHIFT) cnt_nx = cnt + 1'b1;
    end

    // registered serial outputs, one frame bit per SHIFT cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            so <= 1'b0;
            sv <= 1'b0;
            sl <= 1'b0;
        end else begin
            so <= state == SHIFT ? out_bit : 1'b0;
            sv <= state == SHIFT;
            sl <= at_last;
        end

    assign bus.ser_out   = so;
    assign bus.ser_valid = sv;
    assign bus.ser_last  = sl;

endmodule
